instruction_loader: RTL and testbench

Byte-stream program loader that fills the instruction bank from a host link such as a UART receiver. It accepts a length header followed by little-endian 32-bit instruction words and writes them into sequential instruction addresses. It is the writer side of the instruction bank, whose fetch side is read by the decoder. A one-cycle `load_done_out` pulse tells the processor that a complete program is resident.

---
 rtl/instruction_loader.sv | 172 +++++++++++++++++
 tb/tb_instruction_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Byte-stream program loader: length header + little-endian words -> instruction bank writes.
// Ports: clk_in/rst_in, byte stream in (valid/ready), bank write port, load status outputs.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_INSTRUCTIONS  = 16,
  parameter int ADDR_WIDTH        = $clog2(NUM_INSTRUCTIONS)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  output logic                         byte_ready_out,
  output logic                         wr_en_out,
  output logic [ADDR_WIDTH-1:0]        wr_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data_out,
  output logic                         load_active_out,
  output logic                         load_done_out,
  output logic                         load_error_out,
  output logic [ADDR_WIDTH:0]          prog_len_out
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam logic [7:0]            MAX_LEN  = 8'(NUM_INSTRUCTIONS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                       state_q;
  state_t                       state_d;
  logic [1:0]                   byte_cnt_q;
  logic [ADDR_WIDTH-1:0]        word_cnt_q;
  logic [INSTRUCTION_WIDTH-1:0] shift_q;
  logic [ADDR_WIDTH:0]          prog_len_q;
  logic                         err_q;
  logic                         ready_q;
  logic                         wr_en_q;
  logic                         done_q;
  logic                         active_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                   xor_q;
`endif

  logic accept;
  logic hdr_ok;
  logic last_word;

  // ready_q mirrors the current state, so valid&ready is a true handshake
  assign accept    = byte_valid_in & ready_q;
  assign hdr_ok    = (byte_in != 8'd0) && (byte_in <= MAX_LEN);
  assign last_word = ({1'b0, word_cnt_q} + LEN_ONE) >= prog_len_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && hdr_ok) state_d = RECV;
      end
      RECV: begin
        if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (!last_word) state_d = RECV;
`ifdef LOADER_CHECKSUM_EN
        else state_d = CHECK;
`else
        else state_d = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_d = (byte_in == xor_q) ? DONE : IDLE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe without any input-to-output path.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_q  <= 1'b1;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      ready_q  <= (state_d != WRITE) && (state_d != DONE);
      wr_en_q  <= (state_d == WRITE);
      done_q   <= (state_d == DONE);
      active_q <= (state_d != IDLE) && (state_d != DONE);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      prog_len_q <= '0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              prog_len_q <= (ADDR_WIDTH+1)'(byte_in);
              err_q      <= 1'b0;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
              xor_q      <= byte_in;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            shift_q[{byte_cnt_q, 3'b000} +: 8] <= byte_in;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ byte_in;
`endif
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + ADDR_ONE;
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept && byte_in != xor_q) err_q <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign byte_ready_out  = ready_q;
  assign wr_en_out       = wr_en_q;
  assign wr_addr_out     = word_cnt_q;
  assign wr_data_out     = shift_q;
  assign load_active_out = active_q;
  assign load_done_out   = done_q;
  assign load_error_out  = err_q;
  assign prog_len_out    = prog_len_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
// Covers reset, single/full loads, bad headers, stalls, reset mid-load, checksum.
module tb_instruction_loader;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic        wr_en_out;
  logic [3:0]  wr_addr_out;
  logic [31:0] wr_data_out;
  logic        load_active_out;
  logic        load_done_out;
  logic        load_error_out;
  logic [4:0]  prog_len_out;

  instruction_loader #(
    .INSTRUCTION_WIDTH(32),
    .NUM_INSTRUCTIONS(16)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out),
    .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out),
    .load_active_out(load_active_out),
    .load_done_out(load_done_out),
    .load_error_out(load_error_out),
    .prog_len_out(prog_len_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [3:0]  wa_log[$];
  logic [31:0] wd_log[$];
  int          wc_log[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  int          active_seen = 0;
  int          rdy_bad = 0;
  logic [7:0]  cs_acc = 8'd0;

  always @(negedge clk_in) begin
    if (wr_en_out) begin
      wa_log.push_back(wr_addr_out);
      wd_log.push_back(wr_data_out);
      wc_log.push_back(cyc);
      if (byte_ready_out) rdy_bad++;
    end
    if (load_done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (load_active_out) active_seen++;
    if (byte_valid_in && byte_ready_out && !rst_in) acc_cyc = cyc + 1;
  end

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
    wc_log.delete();
    done_cnt = 0;
    active_seen = 0;
    rdy_bad = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bit got;
    n = 0;
    got = 0;
    byte_in = b;
    byte_valid_in = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk_in);
      if (byte_ready_out) got = 1;
      @(posedge clk_in);
      #1;
      n++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted in %0d cycles", b, n);
    end
    cs_acc = cs_acc ^ b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    byte_valid_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    byte_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    tests++; if (byte_ready_out !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0b want 1", byte_ready_out); end
    tests++; if (wr_en_out !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %0b want 0", wr_en_out); end
    tests++; if (wr_addr_out !== 4'd0) begin fails++; $display("FAIL rst_wr_addr: got %0h want 0", wr_addr_out); end
    tests++; if (wr_data_out !== 32'd0) begin fails++; $display("FAIL rst_wr_data: got %0h want 0", wr_data_out); end
    tests++; if (load_active_out !== 1'b0) begin fails++; $display("FAIL rst_active: got %0b want 0", load_active_out); end
    tests++; if (load_done_out !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", load_done_out); end
    tests++; if (load_error_out !== 1'b0) begin fails++; $display("FAIL rst_error: got %0b want 0", load_error_out); end
    tests++; if (prog_len_out !== 5'd0) begin fails++; $display("FAIL rst_prog_len: got %0d want 0", prog_len_out); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    clear_log();
    cs_acc = 8'd0;
    send(8'h10);
    for (int i = 0; i < 16; i++) begin
      w = 32'(i) << 4;
      send_word(w);
    end
`ifdef LOADER_CHECKSUM_EN
    send(cs_acc);
`endif
    idle(4);
    tests++; if (wa_log.size() !== 16) begin fails++; $display("FAIL full_count: got %0d want 16", wa_log.size()); end
    if (wa_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        tests++;
        if (wa_log[i] !== 4'(i) || wd_log[i] !== (32'(i) << 4)) begin
          fails++;
          $display("FAIL full_word%0d: got addr %0h data %0h want addr %0h data %0h",
                   i, wa_log[i], wd_log[i], i, 32'(i) << 4);
        end
      end
      for (int i = 0; i < 15; i++) begin
        tests++;
        if (wc_log[i+1] - wc_log[i] !== 5) begin
          fails++;
          $display("FAIL full_pace%0d: got %0d cycles want 5", i, wc_log[i+1] - wc_log[i]);
        end
      end
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL full_done: got %0d want 1", done_cnt); end
    tests++; if (prog_len_out !== 5'd16) begin fails++; $display("FAIL full_prog_len: got %0d want 16", prog_len_out); end
    tests++; if (rdy_bad !== 0) begin fails++; $display("FAIL full_ready_in_write: got %0d want 0", rdy_bad); end
    tests++; if (load_active_out !== 1'b0) begin fails++; $display("FAIL full_active_end: got %0b want 0", load_active_out); end
  endtask

  task automatic test_bad_header();
    clear_log();
    send(8'h00);
    idle(2);
    tests++; if (load_error_out !== 1'b1) begin fails++; $display("FAIL bad0_error: got %0b want 1", load_error_out); end
    send(8'h11);
    idle(2);
    tests++; if (load_error_out !== 1'b1) begin fails++; $display("FAIL bad17_error: got %0b want 1", load_error_out); end
    tests++; if (wa_log.size() !== 0) begin fails++; $display("FAIL bad_writes: got %0d want 0", wa_log.size()); end
    tests++; if (active_seen !== 0) begin fails++; $display("FAIL bad_active: got %0d want 0", active_seen); end
    tests++; if (prog_len_out !== 5'd16) begin fails++; $display("FAIL bad_prog_len: got %0d want 16", prog_len_out); end
  endtask

  task automatic test_single_word();
    int a4;
    clear_log();
    cs_acc = 8'd0;
    send(8'h01);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    a4 = acc_cyc;
`ifdef LOADER_CHECKSUM_EN
    send(cs_acc);
`endif
    idle(4);
    tests++; if (wa_log.size() !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", wa_log.size()); end
    if (wa_log.size() >= 1) begin
      tests++; if (wa_log[0] !== 4'd0) begin fails++; $display("FAIL single_addr: got %0h want 0", wa_log[0]); end
      tests++; if (wd_log[0] !== 32'h12345678) begin fails++; $display("FAIL single_data: got %0h want 12345678", wd_log[0]); end
      tests++; if (wc_log[0] !== a4) begin fails++; $display("FAIL single_wr_latency: got cyc %0d want %0d", wc_log[0], a4); end
`ifdef LOADER_CHECKSUM_EN
      tests++; if (done_cyc !== acc_cyc) begin fails++; $display("FAIL single_done_latency: got cyc %0d want %0d", done_cyc, acc_cyc); end
`else
      tests++; if (done_cyc !== wc_log[0] + 1) begin fails++; $display("FAIL single_done_latency: got cyc %0d want %0d", done_cyc, wc_log[0] + 1); end
`endif
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    tests++; if (load_error_out !== 1'b0) begin fails++; $display("FAIL single_error_clear: got %0b want 0", load_error_out); end
    tests++; if (prog_len_out !== 5'd1) begin fails++; $display("FAIL single_prog_len: got %0d want 1", prog_len_out); end
    tests++; if (byte_ready_out !== 1'b1) begin fails++; $display("FAIL single_ready_end: got %0b want 1", byte_ready_out); end
  endtask

  task automatic test_stall_reset();
    clear_log();
    send(8'h02);
    send(8'h11);
    send(8'h22);
    idle(7);
    send(8'h33);
    send(8'h44);
    send(8'hAA);
    send(8'hBB);
    byte_valid_in = 1'b0;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    tests++; if (byte_ready_out !== 1'b1) begin fails++; $display("FAIL sr_ready: got %0b want 1", byte_ready_out); end
    tests++; if (load_active_out !== 1'b0) begin fails++; $display("FAIL sr_active: got %0b want 0", load_active_out); end
    tests++; if (prog_len_out !== 5'd0) begin fails++; $display("FAIL sr_prog_len: got %0d want 0", prog_len_out); end
    idle(10);
    tests++; if (wa_log.size() !== 1) begin fails++; $display("FAIL sr_count: got %0d want 1", wa_log.size()); end
    if (wa_log.size() >= 1) begin
      tests++; if (wd_log[0] !== 32'h44332211 || wa_log[0] !== 4'd0) begin
        fails++; $display("FAIL sr_word0: got addr %0h data %0h want addr 0 data 44332211", wa_log[0], wd_log[0]);
      end
    end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL sr_done: got %0d want 0", done_cnt); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    idle(4);
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL cs_good_done: got %0d want 1", done_cnt); end
    tests++; if (load_error_out !== 1'b0) begin fails++; $display("FAIL cs_good_error: got %0b want 0", load_error_out); end
    clear_log();
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h06);
    idle(4);
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL cs_bad_done: got %0d want 0", done_cnt); end
    tests++; if (load_error_out !== 1'b1) begin fails++; $display("FAIL cs_bad_error: got %0b want 1", load_error_out); end
    tests++; if (wa_log.size() !== 1) begin fails++; $display("FAIL cs_bad_writes: got %0d want 1", wa_log.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_bad_header();
    test_single_word();
    test_stall_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
